// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage enable/flush, dcache miss tracking with held load
// data, sticky halt and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic [31:0]      dmemload,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_dest,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_jump,
  input  logic             mem_brtaken,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dmem_mask,
  output logic             use_held,
  output logic [31:0]      held_load,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // state  | meaning
  // RUN    | normal operation, no outstanding data access
  // DWAIT  | MEM-stage access issued, waiting for dhit
  // DDONE  | access finished before ihit; data held, re-issue masked
  // HALTED | halt retired; only reset leaves
  typedef enum logic [1:0] {RUN, DWAIT, DDONE, HALTED} state_t;

  state_t           state_q, state_d;
  logic [31:0]      held_q, held_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             memreq, advance, load_use;

  assign memreq   = mem_dREN | mem_dWEN;
  assign load_use = ex_dREN && (ex_dest != 5'd0) && ((ex_dest == id_rs) || (ex_dest == id_rt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      held_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Outputs are forced low while nRST is asserted, independent of the clock.
  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    advance     = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    dmem_mask   = 1'b0;
    use_held    = 1'b0;
    halt        = 1'b0;
    if (nRST) begin
      if (state_q == HALTED || wb_halt) begin
        halt    = 1'b1;
        state_d = HALTED;
      end else begin
        case (state_q)
          RUN: begin
            if (memreq && !dhit) begin
              state_d = DWAIT;
            end else if (memreq && !ihit) begin
              state_d = DDONE;
              held_d  = dmemload;
            end else begin
              advance = ihit;
            end
          end
          DWAIT: begin
            if (dhit && ihit) begin
              advance = 1'b1;
              state_d = RUN;
            end else if (dhit) begin
              state_d = DDONE;
              held_d  = dmemload;
            end
          end
          DDONE: begin
            dmem_mask = 1'b1;
            use_held  = mem_dREN;
            if (ihit) begin
              advance = 1'b1;
              state_d = RUN;
            end
          end
          default: state_d = HALTED;
        endcase

        if (advance) begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          // Taken branch squashes everything younger, so a pending stall or jump is moot.
          if (mem_brtaken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (id_jump) begin
            ifid_flush = 1'b1;
          end
        end

        if (!pc_en && stall_q != '1)
          stall_d = stall_q + 1'b1;
        if (advance && mem_brtaken && flush_q != '1)
          flush_d = flush_q + 1'b1;
      end
    end
  end

  assign held_load = held_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver predicts each cycle's outputs from a
// rule-level model and queues them; a monitor compares on the falling edge.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 0, dhit = 0, mem_dREN = 0, mem_dWEN = 0;
  logic [31:0] dmemload = '0;
  logic        ex_dREN = 0;
  logic [4:0]  ex_dest = '0, id_rs = '0, id_rt = '0;
  logic        id_jump = 0, mem_brtaken = 0, wb_halt = 0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        dmem_mask, use_held, halt;
  logic [31:0] held_load;
  logic [15:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .dmemload(dmemload), .ex_dREN(ex_dREN), .ex_dest(ex_dest),
    .id_rs(id_rs), .id_rt(id_rt), .id_jump(id_jump), .mem_brtaken(mem_brtaken),
    .wb_halt(wb_halt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .dmem_mask(dmem_mask), .use_held(use_held), .held_load(held_load), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
  //        ifid_flush, idex_flush, exmem_flush, memwb_flush, dmem_mask, use_held, halt}
  typedef struct packed {
    logic [11:0] ctl;
    logic [31:0] held;
    logic [15:0] st;
    logic [15:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: a pending miss, data already returned, halted, plus registers.
  bit          m_wait, m_done, m_halt;
  logic [31:0] m_held;
  int unsigned m_stall, m_flush;

  task automatic drive(input bit r, input bit ih, input bit dh, input bit dr, input bit dw,
                       input logic [31:0] ld, input bit exr, input logic [4:0] exd,
                       input logic [4:0] rs, input logic [4:0] rt, input bit jmp,
                       input bit br, input bit hlt);
    exp_t e;
    bit adv, lu, memreq, p, fe, de, xe, we, ff, df, xf, mk, uh, hl;
    @(posedge CLK);
    #1;
    nRST = r; ihit = ih; dhit = dh; mem_dREN = dr; mem_dWEN = dw; dmemload = ld;
    ex_dREN = exr; ex_dest = exd; id_rs = rs; id_rt = rt; id_jump = jmp;
    mem_brtaken = br; wb_halt = hlt;
    {p, fe, de, xe, we, ff, df, xf, mk, uh, hl} = '0;
    adv = 0;
    if (!r) begin
      m_wait = 0; m_done = 0; m_halt = 0; m_held = '0; m_stall = 0; m_flush = 0;
    end
    e.held = m_held;
    e.st   = 16'(m_stall);
    e.fl   = 16'(m_flush);
    if (r) begin
      memreq = dr | dw;
      if (m_halt || hlt) begin
        hl = 1; m_halt = 1; m_wait = 0; m_done = 0;
      end else begin
        if (m_done) begin
          mk = 1; uh = dr; adv = ih;
        end else if (m_wait) begin
          adv = dh && ih;
          if (dh && !ih) begin m_done = 1; m_held = ld; end
        end else begin
          adv = ih && (!memreq || dh);
          if (memreq && !dh) m_wait = 1;
          else if (memreq && !ih) begin m_done = 1; m_held = ld; end
        end
        if (adv) begin
          m_wait = 0; m_done = 0;
          lu = exr && exd != 0 && (exd == rs || exd == rt);
          {p, fe, de, xe, we} = 5'b11111;
          if (br) {ff, df, xf} = 3'b111;
          else if (lu) begin p = 0; fe = 0; df = 1; end
          else if (jmp) ff = 1;
        end
        if (!p && m_stall < 16'hFFFF) m_stall++;
        if (adv && br && m_flush < 16'hFFFF) m_flush++;
      end
    end
    e.ctl = {p, fe, de, xe, we, ff, df, xf, 1'b0, mk, uh, hl};
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit ih);
    drive(1, ih, 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [11:0] got;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               exmem_flush, memwb_flush, dmem_mask, use_held, halt};
        tests++;
        if (got !== e.ctl) begin
          fails++;
          $display("FAIL ctl t=%0t got=%b want=%b", $time, got, e.ctl);
        end
        tests++;
        if (held_load !== e.held) begin
          fails++;
          $display("FAIL held_load t=%0t got=%h want=%h", $time, held_load, e.held);
        end
        tests++;
        if (stall_cnt !== e.st) begin
          fails++;
          $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.st);
        end
        tests++;
        if (flush_cnt !== e.fl) begin
          fails++;
          $display("FAIL flush_cnt t=%0t got=%0d want=%0d", $time, flush_cnt, e.fl);
        end
      end
    end
  end

  initial begin : stim
    // reset state, then release
    drive(0, 1, 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(1);
    // load miss for three cycles, then hit with ihit
    repeat (3) drive(1, 1, 0, 1, 0, 32'h1111_0000, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 1, 1, 1, 0, 32'h1234_5678, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    // data returns before ihit
    drive(1, 0, 1, 1, 0, 32'hDEAD_BEEF, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 0, 1, 1, 0, 32'h0BAD_F00D, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    // load-use, jump, branch overriding load-use, register zero never hazards
    drive(1, 1, 0, 0, 0, 32'h0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 32'h0, 1, 5'd9, 5'd2, 5'd9, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 32'h0, 1, 5'd8, 5'd8, 5'd3, 1, 1, 0);
    drive(1, 1, 0, 0, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    // halt is sticky and freezes counters
    drive(1, 1, 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    repeat (4) idle(0);
    drive(1, 1, 0, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    // randomized traffic with occasional resets and halts
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) < 3), $urandom,
            ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 19) < 3), ($urandom_range(0, 19) < 3),
            ($urandom_range(0, 249) == 0));
    end
    // stall counter saturation, then reset in the middle of a miss
    drive(0, 0, 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    repeat (65540) idle(0);
    drive(1, 1, 0, 0, 1, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 0, 1, 1, 0, 32'hCAFE_0001, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(1);
    repeat (3) @(posedge CLK);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
